// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: active-low digit patterns, blank, decoder and reader state encoding.
package seg_pkg;

  typedef enum logic {IDLE = 1'b0, TRACK = 1'b1} state_t;

  typedef struct packed {
    logic       ok;
    logic [3:0] value;
  } dec_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0011000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  function automatic dec_t seg_decode(input logic [6:0] pat);
    dec_t d;
    d.ok    = 1'b1;
    d.value = 4'h0;
    case (pat)
      SEG_0: d.value = 4'h0;
      SEG_1: d.value = 4'h1;
      SEG_2: d.value = 4'h2;
      SEG_3: d.value = 4'h3;
      SEG_4: d.value = 4'h4;
      SEG_5: d.value = 4'h5;
      SEG_6: d.value = 4'h6;
      SEG_7: d.value = 4'h7;
      SEG_8: d.value = 4'h8;
      SEG_9: d.value = 4'h9;
      SEG_A: d.value = 4'hA;
      SEG_B: d.value = 4'hB;
      SEG_C: d.value = 4'hC;
      SEG_D: d.value = 4'hD;
      SEG_E: d.value = 4'hE;
      SEG_F: d.value = 4'hF;
      default: d.ok = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/seg_sync_stable.sv
// Two-flop synchronizer followed by a run-length stability filter; strobes accept
// once per stable run whose pattern differs from the last accepted one.
module seg_sync_stable
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [6:0] seg_in,
  output logic       accept,
  output logic [6:0] pattern
);

  localparam logic [7:0] RUN_MAX  = 8'(STABLE_CYCLES);
  localparam logic [7:0] RUN_FIRE = 8'(STABLE_CYCLES - 1);

  logic [6:0] seg_p0, seg_p1, hold_p2;
  logic [7:0] run_cnt;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      seg_p0  <= SEG_BLANK;
      seg_p1  <= SEG_BLANK;
      hold_p2 <= SEG_BLANK;
      run_cnt <= 8'd0;
      accept  <= 1'b0;
      pattern <= SEG_BLANK;
    end else begin
      // stage p0/p1: metastability guard
      seg_p0 <= seg_in;
      seg_p1 <= seg_p0;
      accept <= 1'b0;
      // stage p2: run-length count; saturates so a held pattern fires only once
      if (seg_p1 != hold_p2) begin
        hold_p2 <= seg_p1;
        run_cnt <= 8'd1;
      end else if (run_cnt < RUN_MAX) begin
        run_cnt <= run_cnt + 8'd1;
        if (run_cnt == RUN_FIRE && seg_p1 != pattern) begin
          accept  <= 1'b1;
          pattern <= seg_p1;
        end
      end
    end
  end

endmodule

// File: rtl/hex_reader.sv
// Reads digits from an external active-low 7-segment driver, reporting each new digit,
// illegal patterns, decade-sequence breaks and the cycle period between digits.
module hex_reader
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int PERIOD_W      = 32
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [6:0]          seg_in,
  output logic [3:0]          digit,
  output logic                digit_valid,
  output logic                bad_pattern,
  output logic                seq_err,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid
);

  logic                accept;
  logic [6:0]          pattern;
  dec_t                dec;
  state_t              state;
  logic [PERIOD_W-1:0] per_cnt;

  function automatic logic [PERIOD_W-1:0] sat_inc(input logic [PERIOD_W-1:0] v);
    return (&v) ? v : v + PERIOD_W'(1);
  endfunction

  function automatic logic [3:0] decade_next(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  seg_sync_stable #(.STABLE_CYCLES(STABLE_CYCLES)) u_filter (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .seg_in   (seg_in),
    .accept   (accept),
    .pattern  (pattern)
  );

  assign dec = seg_decode(pattern);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      per_cnt      <= '0;
      digit        <= 4'd0;
      period       <= '0;
      digit_valid  <= 1'b0;
      period_valid <= 1'b0;
      seq_err      <= 1'b0;
      bad_pattern  <= 1'b0;
    end else begin
      // stage p3: classify the accepted pattern and update digit/period
      digit_valid  <= 1'b0;
      period_valid <= 1'b0;
      seq_err      <= 1'b0;
      bad_pattern  <= 1'b0;
      if (state == TRACK) per_cnt <= sat_inc(per_cnt);
      if (accept && pattern != SEG_BLANK) begin
        if (dec.ok) begin
          digit       <= dec.value;
          digit_valid <= 1'b1;
          per_cnt     <= PERIOD_W'(1);
          if (state == IDLE) begin
            state <= TRACK;
          end else begin
            period       <= per_cnt;
            period_valid <= 1'b1;
            seq_err      <= (dec.value != decade_next(digit));
          end
        end else begin
          bad_pattern <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/hex_reader.md
HEX_READER -- requirements
Module: hex_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4; consecutive identical synchronized samples required to accept a pattern (legal range 2..255).
REQ-002 Parameter PERIOD_W, default 32; period counter width.
REQ-003 CLOCK_50  input  1  sole clock; all state rises on posedge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 seg_in  input  7  active-low 7-segment pattern from an external display driver, asynchronous to CLOCK_50; bit 0 = segment a ... bit 6 = segment g.
REQ-006 digit  output  4  last accepted decoded value.
REQ-007 digit_valid  output  1  one-cycle pulse when digit updates.
REQ-008 bad_pattern  output  1  one-cycle pulse on acceptance of a non-hex, non-blank pattern.
REQ-009 seq_err  output  1  one-cycle pulse, coincident with digit_valid, when the new digit is not the decade successor of the previous one.
REQ-010 period  output  PERIOD_W  clock cycles between the last two digit_valid pulses.
REQ-011 period_valid  output  1  one-cycle pulse, coincident with digit_valid, when period updates.

Function
REQ-012 seg_in passes through a 2-flop synchronizer before any use.
REQ-013 Stability filter: the synchronized value is accepted once it has held for STABLE_CYCLES consecutive cycles and differs from the last accepted pattern; shorter excursions produce no output.
REQ-014 Latency from the first clock edge that samples a new stable seg_in to digit_valid high: 2 + STABLE_CYCLES cycles.
REQ-015 Decode table (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-016 Blank (1111111) accepted: updates last accepted pattern only; no pulse, digit unchanged.
REQ-017 Any other accepted pattern: bad_pattern pulses once; digit unchanged; no re-fire until pattern changes.
REQ-018 FSM states: IDLE (no digit accepted since reset) and TRACK.
REQ-019 IDLE: first legal digit -> digit_valid, no period_valid, no seq_err, go to TRACK, period counter cleared to 1.
REQ-020 TRACK: period counter increments every cycle, saturating at 2^PERIOD_W-1; on legal digit -> period = counter, period_valid, counter reloads to 1.
REQ-021 Expected successor = 0 if previous digit >= 9, else previous + 1; mismatch -> seq_err; digits A-F therefore always flag seq_err.
REQ-022 A legal digit equal to the previous digit but reached via blank or bad pattern is re-accepted: digit_valid, period_valid, seq_err all apply.

Reset
REQ-023 resetn low: synchronizer, filter, last pattern = 1111111, FSM = IDLE, digit = 0, period = 0, all pulses 0, immediately and independent of clock.
REQ-024 Reset mid-operation discards any partially stable pattern; a pattern held through reset release is accepted as a fresh IDLE acceptance after full latency.

Structure
REQ-025 Package seg_pkg holds the 16 pattern constants, BLANK constant and the IDLE/TRACK state encoding.
REQ-026 Sub-module seg_sync_stable implements synchronizer plus stability filter, emitting a one-cycle accept strobe with the 7-bit pattern.

Verification
REQ-027 Reset, hold seg_in=1000000 -> digit_valid at cycle 6, digit=0, period_valid=0, seq_err=0.
REQ-028 From 0, drive 1111001 100 cycles after 0 applied -> digit=1, period=100, period_valid=1, seq_err=0.
REQ-029 Sequence 9 -> 0 -> seq_err=0; then 0 -> 0110000 (3) -> digit=3, seq_err=1.
REQ-030 Pulse seg_in to 0100100 for 3 cycles, then back -> no digit_valid, bad_pattern or period change.
REQ-031 Drive 1111111 then 0101010 held 50 cycles -> single bad_pattern pulse, digit unchanged, no digit_valid.
REQ-032 Assert resetn low during TRACK, release with 0011001 held -> all outputs 0 during reset; after release digit=4 with period_valid=0.
